updn_ctr_checker: RTL

Synthesizable on-line checker for a WIDTH-bit up/down counter with synchronous load, count enable and terminal count. It sits beside the counter and samples the same control inputs and the counter's count/tercnt outputs. It keeps its own model of the expected count and raises sticky error flags on any divergence. It also counts terminal-count wrap events for bring-up and regression benches.

---
 rtl/updn_ctr_checker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/updn_ctr_checker.sv
// On-line checker for a WIDTH-bit up/down counter: mirrors the expected count, flags
// count/tercnt divergence with sticky errors and first-error captures, and counts wraps.
module updn_ctr_checker #(
  parameter int WIDTH = 3,
  parameter int EVW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_err,
  input  logic             obs_load,
  input  logic             obs_cen,
  input  logic             obs_up_dn,
  input  logic [WIDTH-1:0] obs_data,
  input  logic [WIDTH-1:0] obs_count,
  input  logic             obs_tercnt,
  output logic             chk_active,
  output logic             err,
  output logic             err_cnt,
  output logic             err_tc,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_obs,
  output logic [EVW-1:0]   wrap_events
);

  typedef enum logic [1:0] {SYNC, TRACK, FAIL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic [WIDTH-1:0] first_obs_q, first_obs_d;
  logic             err_cnt_q, err_cnt_d;
  logic             err_tc_q, err_tc_d;
  logic             err_q, err_d;
  logic             chk_active_q, chk_active_d;
  logic [EVW-1:0]   wrap_q, wrap_d;

  logic [WIDTH-1:0] pred;
  logic             tc_exp;
  logic             mis_cnt;
  logic             mis_tc;

  // Next count the counter should produce from what it shows now; load beats enable.
  always_comb begin
    pred = obs_count;
    if (!obs_load) begin
      pred = obs_data;
    end else if (obs_cen) begin
      pred = obs_up_dn ? obs_count + 1'b1 : obs_count - 1'b1;
    end
  end

  assign tc_exp  = obs_up_dn ? (&obs_count) : (obs_count == '0);
  assign mis_cnt = (obs_count != exp_q);
  assign mis_tc  = (obs_tercnt != tc_exp);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    first_exp_d = first_exp_q;
    first_obs_d = first_obs_q;
    err_cnt_d   = err_cnt_q;
    err_tc_d    = err_tc_q;
    wrap_d      = wrap_q;
    if (clr_err) begin
      state_d     = SYNC;
      first_exp_d = '0;
      first_obs_d = '0;
      err_cnt_d   = 1'b0;
      err_tc_d    = 1'b0;
      wrap_d      = '0;
    end else begin
      case (state_q)
        SYNC: begin
          exp_d   = pred;
          state_d = TRACK;
        end
        TRACK: begin
          if (mis_cnt || mis_tc) begin
            if (!(err_cnt_q || err_tc_q)) begin
              first_exp_d = exp_q;
              first_obs_d = obs_count;
            end
            err_cnt_d = err_cnt_q | mis_cnt;
            err_tc_d  = err_tc_q | mis_tc;
            state_d   = FAIL;
          end else begin
            exp_d = pred;
            if (obs_load && obs_cen && obs_tercnt && (wrap_q != '1)) begin
              wrap_d = wrap_q + 1'b1;
            end
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end
    err_d        = err_cnt_d | err_tc_d;
    chk_active_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SYNC;
      exp_q        <= '0;
      first_exp_q  <= '0;
      first_obs_q  <= '0;
      err_cnt_q    <= 1'b0;
      err_tc_q     <= 1'b0;
      err_q        <= 1'b0;
      chk_active_q <= 1'b0;
      wrap_q       <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      first_exp_q  <= first_exp_d;
      first_obs_q  <= first_obs_d;
      err_cnt_q    <= err_cnt_d;
      err_tc_q     <= err_tc_d;
      err_q        <= err_d;
      chk_active_q <= chk_active_d;
      wrap_q       <= wrap_d;
    end
  end

  assign chk_active  = chk_active_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
  assign err_tc      = err_tc_q;
  assign first_exp   = first_exp_q;
  assign first_obs   = first_obs_q;
  assign wrap_events = wrap_q;

endmodule
